// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, returned words buffered with their PC.
// Optional misaligned-redirect trap with fetch halt: define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter int                   wd_regs_p    = 32,
  parameter logic [wd_regs_p-1:0] reset_pc_p   = '0,
  parameter int                   fifo_depth_p = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_br_taken,
  input  logic [wd_regs_p-1:0] i_br_pc,
  output logic                 o_imem_req,
  output logic [wd_regs_p-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [31:0]          i_imem_rdata,
  output logic                 o_instr_valid,
  output logic [31:0]          o_instr,
  output logic [wd_regs_p-1:0] o_instr_pc,
  input  logic                 i_instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                 o_misalign
`endif
);

  localparam int ptr_w_c = (fifo_depth_p > 1) ? $clog2(fifo_depth_p) : 1;
  localparam int cnt_w_c = $clog2(fifo_depth_p + 1);
  localparam logic [cnt_w_c-1:0] depth_c    = cnt_w_c'(fifo_depth_p);
  localparam logic [ptr_w_c-1:0] last_ptr_c = ptr_w_c'(fifo_depth_p - 1);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DRAIN} state_t;

  state_t               state_reg, state_next;
  logic [wd_regs_p-1:0] pc_reg, pc_next;
  logic [wd_regs_p-1:0] inflight_reg, inflight_next;
  logic                 req_reg, req_next;
  logic [cnt_w_c-1:0]   count_reg, count_next;
  logic [ptr_w_c-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [ptr_w_c-1:0]   wr_ptr_reg, wr_ptr_next;
  logic                 push, pop, flush, halt_next;

  logic [31:0]          instr_mem [fifo_depth_p];
  logic [wd_regs_p-1:0] pc_mem    [fifo_depth_p];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_reg, misalign_reg, misalign_next;
  assign o_misalign = misalign_reg;
`else
  logic br_pc_lo_unused;
  assign br_pc_lo_unused = ^i_br_pc[1:0];
`endif

  function automatic logic [ptr_w_c-1:0] ptr_inc(input logic [ptr_w_c-1:0] p);
    return (p == last_ptr_c) ? '0 : p + 1'b1;
  endfunction

  assign o_imem_req    = req_reg;
  assign o_imem_addr   = pc_reg;
  assign o_instr_valid = (count_reg != '0) & ~i_br_taken;
  assign o_instr       = instr_mem[rd_ptr_reg];
  assign o_instr_pc    = pc_mem[rd_ptr_reg];
  assign pop           = o_instr_valid & i_instr_ready;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inflight_next = inflight_reg;
    push          = 1'b0;
    flush         = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_next     = halt_reg;
    misalign_next = 1'b0;
`else
    halt_next     = 1'b0;
`endif
    case (state_reg)
      ST_REQ: begin
        if (req_reg && i_imem_gnt) begin
          inflight_next = pc_reg;
          state_next    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          push       = 1'b1;
          pc_next    = pc_reg + wd_regs_p'(4);
          state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (i_imem_rvalid) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase

    // A redirect overrides the normal step; any response already in flight is dropped.
    if (i_br_taken) begin
      pc_next = {i_br_pc[wd_regs_p-1:2], 2'b00};
      flush   = 1'b1;
      push    = 1'b0;
      case (state_reg)
        ST_REQ:   state_next = (req_reg && i_imem_gnt) ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_next = i_imem_rvalid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_next = i_imem_rvalid ? ST_REQ : ST_DRAIN;
        default:  state_next = ST_REQ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_next     = |i_br_pc[1:0];
      misalign_next = |i_br_pc[1:0];
`endif
    end

    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (flush) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_next = count_reg + 1'b1;
      else if (pop && !push) count_next = count_reg - 1'b1;
    end

    // Request is registered, so it is derived from the next-cycle state and occupancy.
    req_next = (state_next == ST_REQ) && (count_next < depth_c) && !halt_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_REQ;
      pc_reg       <= reset_pc_p;
      inflight_reg <= '0;
      req_reg      <= 1'b0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_reg     <= 1'b0;
      misalign_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inflight_reg <= inflight_next;
      req_reg      <= req_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_reg     <= halt_next;
      misalign_reg <= misalign_next;
`endif
    end
  end

  for (genvar gi = 0; gi < fifo_depth_p; gi++) begin : g_entry
    logic [31:0]          instr_reg;
    logic [wd_regs_p-1:0] tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        instr_reg <= '0;
        tag_reg   <= '0;
      end else if (push && (wr_ptr_reg == ptr_w_c'(gi))) begin
        instr_reg <= i_imem_rdata;
        tag_reg   <= inflight_reg;
      end
    end

    assign instr_mem[gi] = instr_reg;
    assign pc_mem[gi]    = tag_reg;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected requests/instructions, a monitor checks them.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        i_br_taken;
  logic [31:0] i_br_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  int          errors = 0;
  int          checks = 0;
  int          gnt_budget = 0;
  bit          auto_resp = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];

  fetch_unit #(
    .wd_regs_p   (32),
    .reset_pc_p  (32'h0000_0000),
    .fifo_depth_p(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_br_taken   (i_br_taken),
    .i_br_pc      (i_br_pc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_instr_valid(o_instr_valid),
    .o_instr      (o_instr),
    .o_instr_pc   (o_instr_pc),
    .i_instr_ready(i_instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_misalign   (o_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_empty(input string name);
    checks++;
    if (exp_addr_q.size() != 0 || exp_instr_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d reqs/%0d instrs pending expected 0/0",
               name, exp_addr_q.size(), exp_instr_q.size());
    end
  endtask

  task automatic set_budget(input int n);
    gnt_budget = n;
    i_imem_gnt = (n > 0);
  endtask

  task automatic exp_instr(input logic [31:0] data, input logic [31:0] pc);
    exp_instr_q.push_back({data, pc});
  endtask

  // One clock: sample the grant mid-cycle, then drive next-cycle inputs just after the edge.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    @(negedge clk);
    g = o_imem_req && i_imem_gnt;
    a = o_imem_addr;
    if (g && gnt_budget > 0) gnt_budget--;
    @(posedge clk);
    #1;
    i_imem_gnt = (gnt_budget > 0);
    if (auto_resp) begin
      i_imem_rvalid = g;
      i_imem_rdata  = g ? {16'hC0DE, a[15:0]} : 32'h0;
    end
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin : monitor
    logic [31:0] ea;
    logic [63:0] ei;
    forever begin
      @(negedge clk);
      if (rst_n && o_imem_req && i_imem_gnt) begin
        $display("req   addr=0x%08h", o_imem_addr);
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr 0x%08h expected no request", o_imem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("req_addr", {32'h0, o_imem_addr}, {32'h0, ea});
        end
      end
      if (o_instr_valid && i_instr_ready) begin
        $display("instr pc=0x%08h data=0x%08h", o_instr_pc, o_instr);
        if (exp_instr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc 0x%08h data 0x%08h expected none", o_instr_pc, o_instr);
        end else begin
          ei = exp_instr_q.pop_front();
          chk("instr", {o_instr, o_instr_pc}, ei);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n         = 1'b0;
    i_br_taken    = 1'b0;
    i_br_pc       = 32'h0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    i_instr_ready = 1'b0;
    repeat (3) tick();
    settle();
    chk("reset_req",      {63'h0, o_imem_req}, 64'h0);
    chk("reset_valid",    {63'h0, o_instr_valid}, 64'h0);
    chk("reset_instr",    {32'h0, o_instr}, 64'h0);
    chk("reset_instr_pc", {32'h0, o_instr_pc}, 64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("reset_misalign", {63'h0, o_misalign}, 64'h0);
`endif

    // Streaming from reset PC with immediate grant and next-cycle response.
    rst_n         = 1'b1;
    i_instr_ready = 1'b1;
    auto_resp     = 1'b1;
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0004);
    exp_addr_q.push_back(32'h0000_0008);
    exp_instr(32'hC0DE_0000, 32'h0000_0000);
    exp_instr(32'hC0DE_0004, 32'h0000_0004);
    exp_instr(32'hC0DE_0008, 32'h0000_0008);
    set_budget(3);
    repeat (10) tick();
    chk_empty("stream_drained");

    // Back-pressure: buffer fills to depth, requests stop, one pop allows exactly one refetch.
    i_instr_ready = 1'b0;
    exp_addr_q.push_back(32'h0000_000C);
    exp_addr_q.push_back(32'h0000_0010);
    exp_instr(32'hC0DE_000C, 32'h0000_000C);
    exp_instr(32'hC0DE_0010, 32'h0000_0010);
    set_budget(2);
    repeat (8) tick();
    settle();
    chk("full_req_low",   {63'h0, o_imem_req}, 64'h0);
    chk("full_valid",     {63'h0, o_instr_valid}, 64'h1);
    chk("full_head",      {o_instr, o_instr_pc}, {32'hC0DE_000C, 32'h0000_000C});
    exp_addr_q.push_back(32'h0000_0014);
    exp_instr(32'hC0DE_0014, 32'h0000_0014);
    set_budget(2);
    repeat (2) tick();
    settle();
    chk("full_req_held",  {63'h0, o_imem_req}, 64'h0);
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    repeat (6) tick();
    settle();
    chk("refill_req_low", {63'h0, o_imem_req}, 64'h0);
    set_budget(0);
    i_instr_ready = 1'b1;
    repeat (4) tick();
    chk_empty("backpressure_drained");

    // Redirect while waiting; the late response must be discarded.
    auto_resp = 1'b0;
    exp_addr_q.push_back(32'h0000_0018);
    set_budget(1);
    tick();
    i_br_taken = 1'b1;
    i_br_pc    = 32'h0000_0100;
    settle();
    chk("wait_redirect_valid", {63'h0, o_instr_valid}, 64'h0);
    tick();
    i_br_taken = 1'b0;
    settle();
    chk("drain_req_low", {63'h0, o_imem_req}, 64'h0);
    tick();
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hDEAD_BEEF;
    settle();
    chk("drain_req_low2", {63'h0, o_imem_req}, 64'h0);
    tick();
    i_imem_rvalid = 1'b0;
    settle();
    chk("redirect_req",   {63'h0, o_imem_req}, 64'h1);
    chk("redirect_addr",  {32'h0, o_imem_addr}, {32'h0, 32'h0000_0100});
    chk("redirect_empty", {63'h0, o_instr_valid}, 64'h0);
    auto_resp = 1'b1;
    exp_addr_q.push_back(32'h0000_0100);
    exp_instr(32'hC0DE_0100, 32'h0000_0100);
    set_budget(1);
    repeat (6) tick();
    chk_empty("redirect_wait_drained");

    // Redirect coinciding with rvalid: response dropped, buffered word flushed.
    auto_resp     = 1'b0;
    i_instr_ready = 1'b0;
    exp_addr_q.push_back(32'h0000_0104);
    set_budget(1);
    tick();
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hC0DE_0104;
    tick();
    i_imem_rvalid = 1'b0;
    exp_addr_q.push_back(32'h0000_0108);
    set_budget(1);
    tick();
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hBADC_0DE0;
    i_br_taken    = 1'b1;
    i_br_pc       = 32'h0000_0200;
    i_instr_ready = 1'b1;
    settle();
    chk("br_forces_valid_low", {63'h0, o_instr_valid}, 64'h0);
    tick();
    i_imem_rvalid = 1'b0;
    i_br_taken    = 1'b0;
    settle();
    chk("flushed_valid",  {63'h0, o_instr_valid}, 64'h0);
    chk("rvalid_br_req",  {63'h0, o_imem_req}, 64'h1);
    chk("rvalid_br_addr", {32'h0, o_imem_addr}, {32'h0, 32'h0000_0200});
    auto_resp = 1'b1;
    exp_addr_q.push_back(32'h0000_0200);
    exp_instr(32'hC0DE_0200, 32'h0000_0200);
    set_budget(1);
    repeat (6) tick();
    chk_empty("rvalid_redirect_drained");

    // PC wraps past the top of the address space.
    i_br_taken = 1'b1;
    i_br_pc    = 32'hFFFF_FFFC;
    tick();
    i_br_taken = 1'b0;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_instr(32'hC0DE_FFFC, 32'hFFFF_FFFC);
    exp_instr(32'hC0DE_0000, 32'h0000_0000);
    set_budget(2);
    repeat (8) tick();
    chk_empty("wrap_drained");

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect halts fetch until an aligned redirect arrives.
    i_br_taken = 1'b1;
    i_br_pc    = 32'h0000_0102;
    tick();
    i_br_taken = 1'b0;
    settle();
    chk("misalign_pulse",  {63'h0, o_misalign}, 64'h1);
    chk("halt_req_low",    {63'h0, o_imem_req}, 64'h0);
    set_budget(1);
    tick();
    settle();
    chk("misalign_clear",  {63'h0, o_misalign}, 64'h0);
    chk("halt_req_low2",   {63'h0, o_imem_req}, 64'h0);
    repeat (3) tick();
    exp_addr_q.push_back(32'h0000_0104);
    exp_instr(32'hC0DE_0104, 32'h0000_0104);
    i_br_taken = 1'b1;
    i_br_pc    = 32'h0000_0104;
    tick();
    i_br_taken = 1'b0;
    settle();
    chk("resume_no_misalign", {63'h0, o_misalign}, 64'h0);
    repeat (6) tick();
    chk_empty("resume_drained");
`endif

    set_budget(0);
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Produces the instruction/PC stream that decode and execute consume.
- Consumes the branch-redirect (target PC, taken) that execute produces.
- Issues word fetches to instruction memory over a req/gnt/rvalid interface, with at most one request outstanding.
- Buffers returned words in a small FIFO with a valid/ready output.

Parameters:
- wd_regs_p, 32: PC and address width.
- reset_pc_p, 32'h0000_0000: PC fetched first after reset.
- fifo_depth_p, 2: instruction buffer entries, must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_br_taken  in  1  redirect request from execute
- i_br_pc  in  wd_regs_p  redirect target
- o_imem_req  out  1  fetch request
- o_imem_addr  out  wd_regs_p  fetch address, word aligned
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  response data valid
- i_imem_rdata  in  32  instruction word
- o_instr_valid  out  1  buffer head valid
- o_instr  out  32  head instruction
- o_instr_pc  out  wd_regs_p  head instruction PC
- i_instr_ready  in  1  consumer accepts head

Behaviour:
- Reset values:
  - fetch PC = reset_pc_p
  - state = REQ
  - FIFO count = 0, all entries = 0
  - o_imem_req = 0, o_instr_valid = 0, o_instr = 0, o_instr_pc = 0
- FSM states:
  - REQ:
    - o_imem_req = (count < fifo_depth_p); o_imem_addr = fetch PC.
    - On req & gnt: record the in-flight PC and go to WAIT.
    - While ungranted, the address may change only due to a redirect.
  - WAIT:
    - o_imem_req = 0.
    - On rvalid: push {rdata, in-flight PC}, fetch PC += 4 (wraps modulo 2^wd_regs_p), go to REQ.
  - DRAIN:
    - o_imem_req = 0.
    - On rvalid: discard the data and go to REQ. Fetch PC already holds the redirect target.
- Redirect (i_br_taken = 1), applied at the clock edge:
  - Fetch PC is set to {i_br_pc[wd-1:2], 2'b00} and the FIFO is flushed (count = 0).
  - Next state depends on the state and inputs in the same cycle:
    - REQ without gnt -> REQ, new address next cycle.
    - REQ with gnt -> DRAIN.
    - WAIT without rvalid -> DRAIN.
    - WAIT with rvalid -> REQ, response dropped.
    - DRAIN -> DRAIN, pending response still dropped.
  - o_instr_valid is forced 0 in any cycle with i_br_taken = 1, so no handshake completes on the flushed stream.
- FIFO:
  - o_instr_valid = (count != 0) & !i_br_taken; o_instr and o_instr_pc show the head entry.
  - Pop on o_instr_valid & i_instr_ready.
  - Push and pop in the same cycle: count unchanged, head advances, and the new entry is written at the tail.
  - Overflow is impossible: a request is issued only when count < depth, and only one is outstanding.
  - Pointers wrap modulo fifo_depth_p; the pointer width is sized for non-power-of-two depths.
- Latency:
  - Best case, with gnt in the request cycle and rvalid on the next cycle: the word is visible on o_instr the cycle after rvalid.
  - Sustained throughput is one instruction per 2 cycles (single outstanding request).
- Reset asserted mid-operation: all state returns to reset values immediately. Any later memory response is ignored, because rvalid is only sampled in WAIT and DRAIN.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port o_misalign (1 bit, reset 0).
  - A redirect with i_br_pc[1:0] != 0 takes the normal flush/state actions described above.
  - It also pulses o_misalign high for exactly the next cycle and sets a halt flag.
  - While halted, o_imem_req = 0, though a pending DRAIN response is still consumed.
  - The halt flag clears only on a subsequent aligned redirect.
- Undefined: the port is absent, i_br_pc[1:0] is silently ignored, and no halt occurs.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, ready = 1 -> addresses 0x0, 0x4, 0x8 in order; o_instr_pc tracks them; every word is delivered once.
- ready = 0, depth 2 -> two words are buffered, then o_imem_req stays 0. ready = 1 for one cycle -> one pop, then exactly one new request.
- Redirect to 0x100 while in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> that word is never output; the next request address is 0x100; the FIFO is empty after the redirect.
- Redirect to 0x200 in the same cycle as rvalid in WAIT -> the response is dropped, the FSM returns to REQ, and the next address is 0x200. The same cycle with ready = 1 shows o_instr_valid = 0.
- PC wrap: redirect to 0xFFFF_FFFC -> the fetch after it is addressed 0x0000_0000.
- FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> o_misalign high for exactly one cycle, no requests issued. Redirect to 0x104 -> fetching resumes at 0x104.
